// File: rtl/framebuffer_scanout_pkg.sv
// Shared SDRAM command encodings, framebuffer geometry and scanout FSM states.
package framebuffer_scanout_pkg;
  localparam logic [1:0]  CMD_IDLE          = 2'b00;
  localparam logic [1:0]  CMD_READ          = 2'b01;
  localparam logic [1:0]  CMD_WRITE         = 2'b10;
  localparam int          READ_BURST_LENGTH = 8;
  localparam logic [21:0] FB_BASE           = 22'h0;
  localparam int          FB_WORDS          = 96000;

  typedef enum logic [1:0] {
    SO_IDLE = 2'd0,
    SO_REQ  = 2'd1,
    SO_READ = 2'd2
  } scanout_state_e;
endpackage

// File: rtl/framebuffer_scanout_word_fifo.sv
// Single-clock word FIFO with a second read port on the entry behind the head,
// so the unpacker can roll straight into the next word without a bubble.
module scanout_word_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [31:0]   data_o,
  output logic [31:0]   next_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   free_o
);
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q, rp_nx;
  logic [AW:0]   cnt_q;

  assign rp_nx   = rp_q + AW'(1);
  assign data_o  = mem_q[rp_q];
  assign next_o  = mem_q[rp_nx];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign free_o  = (AW+1)'(DEPTH) - cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wp_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i)  rp_q <= rp_nx;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/framebuffer_scanout.sv
// Display-side SDRAM client: bursts 8bpp framebuffer words into a FIFO and
// streams them out one pixel per accepted beat, LSB byte first.
module framebuffer_scanout #(
  parameter int          BURST_LEN  = framebuffer_scanout_pkg::READ_BURST_LENGTH,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [21:0] FB_BASE    = framebuffer_scanout_pkg::FB_BASE,
  parameter int          FB_WORDS   = framebuffer_scanout_pkg::FB_WORDS
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Frame_Start,
  output logic        o_SDRAM_Request,
  input  logic        i_SDRAM_Yield,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  input  logic        i_Data_Read_Valid,
  input  logic [31:0] i_Data_Read,
  output logic [7:0]  o_Pixel,
  output logic        o_Pixel_Valid,
  input  logic        i_Pixel_Ready,
  output logic        o_Underrun
);
  import framebuffer_scanout_pkg::*;

  localparam int          FAW        = $clog2(FIFO_DEPTH);
  localparam int          BCW        = $clog2(BURST_LEN + 1);
  localparam logic [21:0] LAST_ADDR  = FB_BASE + 22'(FB_WORDS - 1);
  localparam logic [FAW:0] BURST_FREE = (FAW+1)'(BURST_LEN);
  localparam logic [FAW:0] TWO_USED   = (FAW+1)'(FIFO_DEPTH - 2);

  scanout_state_e state_q;
  logic           req_q, active_q, restart_q;
  logic [1:0]     cmd_q;
  logic [21:0]    addr_q, rd_ptr_q;
  logic [BCW-1:0] beat_q;

  logic           pv_q, pv_d, under_q;
  logic [7:0]     px_q, px_d;
  logic [1:0]     idx_q, idx_d;
  logic [2:0]     blank_q;

  logic           push, pop, flush, fifo_full, fifo_empty;
  logic           last_beat, discard;
  logic [FAW:0]   fifo_free;
  logic [31:0]    head_w, next_w;

  assign last_beat = (state_q == SO_READ) && i_Data_Read_Valid &&
                     (beat_q == BCW'(BURST_LEN - 1));
  // A restart seen during a burst drops every word still in flight.
  assign discard   = restart_q | i_Frame_Start;
  assign push      = (state_q == SO_READ) && i_Data_Read_Valid && !discard;
  assign flush     = i_Frame_Start | (last_beat & restart_q);

  scanout_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_Clk),
    .rst_ni  (i_Rst_n),
    .push_i  (push),
    .data_i  (i_Data_Read),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head_w),
    .next_o  (next_w),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q   <= SO_IDLE;
      req_q     <= 1'b0;
      cmd_q     <= CMD_IDLE;
      addr_q    <= FB_BASE;
      rd_ptr_q  <= FB_BASE;
      beat_q    <= '0;
      active_q  <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      if (i_Frame_Start) active_q <= 1'b1;
      case (state_q)
        SO_IDLE: begin
          if (i_Frame_Start) rd_ptr_q <= FB_BASE;
          if ((active_q || i_Frame_Start) && !fifo_full && fifo_free >= BURST_FREE) begin
            state_q <= SO_REQ;
            req_q   <= 1'b1;
          end
        end
        SO_REQ: begin
          if (i_Frame_Start) rd_ptr_q <= FB_BASE;
          if (i_SDRAM_Yield) begin
            state_q   <= SO_READ;
            cmd_q     <= CMD_READ;
            addr_q    <= i_Frame_Start ? FB_BASE : rd_ptr_q;
            beat_q    <= '0;
            restart_q <= 1'b0;
          end
        end
        SO_READ: begin
          if (i_Frame_Start) restart_q <= 1'b1;
          if (i_Data_Read_Valid) begin
            addr_q <= addr_q + 22'd1;
            beat_q <= beat_q + BCW'(1);
            if (last_beat) begin
              state_q   <= SO_IDLE;
              req_q     <= 1'b0;
              cmd_q     <= CMD_IDLE;
              restart_q <= 1'b0;
              if (discard || addr_q == LAST_ADDR) rd_ptr_q <= FB_BASE;
              else                                rd_ptr_q <= rd_ptr_q + 22'(BURST_LEN);
            end
          end
        end
        default: state_q <= SO_IDLE;
      endcase
    end
  end

  // idx_q is the byte position of the held pixel within the FIFO head word;
  // the head is popped only once its last byte leaves the output register.
  always_comb begin
    pv_d  = pv_q;
    px_d  = px_q;
    idx_d = idx_q;
    pop   = 1'b0;
    if (flush) begin
      pv_d  = 1'b0;
      idx_d = 2'd0;
    end else if (pv_q && i_Pixel_Ready) begin
      if (idx_q == 2'd3) begin
        pop   = 1'b1;
        idx_d = 2'd0;
        pv_d  = (fifo_free <= TWO_USED);
        px_d  = next_w[7:0];
      end else begin
        idx_d = idx_q + 2'd1;
        px_d  = head_w[{idx_d, 3'b000} +: 8];
      end
    end else if (!pv_q && !fifo_empty) begin
      pv_d  = 1'b1;
      idx_d = 2'd0;
      px_d  = head_w[7:0];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      pv_q    <= 1'b0;
      px_q    <= 8'h00;
      idx_q   <= 2'd0;
      under_q <= 1'b0;
      blank_q <= 3'd0;
    end else begin
      pv_q    <= pv_d;
      px_q    <= px_d;
      idx_q   <= idx_d;
      under_q <= active_q && i_Pixel_Ready && !pv_q && (blank_q == 3'd0) && !flush;
      if (flush)                blank_q <= 3'd4;
      else if (blank_q != 3'd0) blank_q <= blank_q - 3'd1;
    end
  end

  assign o_SDRAM_Request = req_q;
  assign o_Command       = cmd_q;
  assign o_Data_Address  = addr_q;
  assign o_Pixel         = px_q;
  assign o_Pixel_Valid   = pv_q;
  assign o_Underrun      = under_q;
endmodule
